// File: rtl/montgomery_reduce_stream.sv
// Streaming Montgomery reduction r = x * 2^-k mod m with a fixed-latency,
// stall-able pipeline; each operand carries its tag through every stage.
module montgomery_reduce_stream #(
  parameter int W          = 64,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_we_i,
  input  logic [W-1:0]           cfg_m_i,
  input  logic [W-1:0]           cfg_minv_i,
  input  logic [$clog2(W+1)-1:0] cfg_k_i,
  output logic                   cfg_rej_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*W-1:0]         in_x_i,
  input  logic [TAG_W-1:0]       in_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [W-1:0]           out_r_o,
  output logic [TAG_W-1:0]       out_tag_o,
  output logic                   busy_o
);

  localparam int KW  = $clog2(W+1);
  localparam int MS  = MUL_STAGES;
  localparam int LAT = 2*MS + 2;

  logic [W-1:0]  m_q, minv_q;
  logic [KW-1:0] k_q;
  logic          configured;

  // vld[0] = input register, vld[LAT-1] = output register
  logic [LAT-1:0] vld;

  logic [2*W-1:0]   x_s   [0:2*MS];
  logic [TAG_W-1:0] tag_s [0:2*MS];
  logic [W-1:0]     q_s   [1:MS];
  logic [2*W-1:0]   qm_s  [MS+1:2*MS];

  logic           stall, adv, accept, cfg_ok, cfg_take;
  logic [W-1:0]   kmask, cfg_hi, q_new, r_next;
  logic [2*W-1:0] qm_new;
  logic [2*W:0]   t_w, m_ext;

  assign stall       = vld[LAT-1] & ~out_ready_i;
  assign adv         = ~stall;
  assign in_ready_o  = configured & ~stall;
  assign accept      = in_valid_i & in_ready_o;
  assign busy_o      = |vld;
  assign out_valid_o = vld[LAT-1];

  // Shifts by >= W yield zero, so k = W gives an all-ones mask / empty high field.
  assign kmask  = ~({W{1'b1}} << k_q);
  assign cfg_hi = {W{1'b1}} << cfg_k_i;
  assign cfg_ok = cfg_m_i[0] && (cfg_k_i != '0) && (cfg_k_i <= KW'(W))
                  && ((cfg_m_i & cfg_hi) == '0);
  // An accept in the same cycle counts as busy.
  assign cfg_take = cfg_we_i & cfg_ok & ~busy_o & ~accept;

  always_comb begin
    q_new  = (x_s[0][W-1:0] * minv_q) & kmask;
    qm_new = {{W{1'b0}}, q_s[MS]} * {{W{1'b0}}, m_q};
    t_w    = ({1'b0, x_s[2*MS]} + {1'b0, qm_s[2*MS]}) >> k_q;
    m_ext  = {{(W+1){1'b0}}, m_q};
    r_next = (t_w >= m_ext) ? W'(t_w - m_ext) : t_w[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld        <= '0;
      configured <= 1'b0;
      cfg_rej_o  <= 1'b0;
      out_r_o    <= '0;
      out_tag_o  <= '0;
    end else begin
      cfg_rej_o <= cfg_we_i & ~cfg_take;
      if (cfg_take) configured <= 1'b1;
      if (adv) begin
        vld <= {vld[LAT-2:0], accept};
        if (vld[LAT-2]) begin
          out_r_o   <= r_next;
          out_tag_o <= tag_s[2*MS];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cfg_take) begin
      m_q    <= cfg_m_i;
      minv_q <= cfg_minv_i;
      k_q    <= cfg_k_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      x_s[0]   <= in_x_i;
      tag_s[0] <= in_tag_i;
      for (int unsigned i = 1; i <= 2*MS; i++) begin
        x_s[i]   <= x_s[i-1];
        tag_s[i] <= tag_s[i-1];
      end
      q_s[1] <= q_new;
      for (int unsigned i = 2; i <= MS; i++) q_s[i] <= q_s[i-1];
      qm_s[MS+1] <= qm_new;
      for (int unsigned i = MS+2; i <= 2*MS; i++) qm_s[i] <= qm_s[i-1];
    end
  end

endmodule

// File: tb/tb_montgomery_reduce_stream.sv
// Self-checking bench: queue-based reference model of x*2^-k mod m plus
// directed literal vectors for config, stall, reset and boundary behaviour.
module tb_montgomery_reduce_stream;
  localparam int W = 64, MS = 2, TAG_W = 4, KW = 7, LAT = 6;

  logic             clk_i = 1'b0, rst_ni;
  logic             cfg_we_i, cfg_rej_o;
  logic [W-1:0]     cfg_m_i, cfg_minv_i;
  logic [KW-1:0]    cfg_k_i;
  logic             in_valid_i, in_ready_o;
  logic [2*W-1:0]   in_x_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o, out_ready_i;
  logic [W-1:0]     out_r_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             busy_o;

  montgomery_reduce_stream #(.W(W), .MUL_STAGES(MS), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_m_i(cfg_m_i), .cfg_minv_i(cfg_minv_i),
    .cfg_k_i(cfg_k_i), .cfg_rej_o(cfg_rej_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_x_i(in_x_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_r_o(out_r_o), .out_tag_o(out_tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: reduce mod m, then divide by 2 mod m k times.
  function automatic logic [63:0] mont_ref(input logic [127:0] x, input logic [63:0] m, input int k);
    logic [65:0] r;
    r = 66'(x % {64'b0, m});
    for (int i = 0; i < k; i++) r = r[0] ? (r + {2'b0, m}) >> 1 : r >> 1;
    return r[63:0];
  endfunction

  function automatic logic [63:0] calc_minv(input logic [63:0] m);
    logic [63:0] inv;
    inv = m;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - m * inv);
    return -inv;
  endfunction

  typedef struct { logic [63:0] r; logic [3:0] tag; int c; } exp_t;
  exp_t        expq[$];
  logic [63:0] log_r[$];
  logic [3:0]  log_t[$];
  logic [63:0] cm = 64'd1;
  int          ck = 1;
  bit          check_lat = 0, rand_ready = 0, prev_stall = 0;
  logic [63:0] prev_r;
  logic [3:0]  prev_t;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      expq.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", out_valid_o, 1);
        check("stall_r_hold", out_r_o, prev_r);
        check("stall_tag_hold", out_tag_o, prev_t);
      end
      if (out_valid_o && !out_ready_i) check("in_ready_in_stall", in_ready_o, 0);
      if (out_valid_o && out_ready_i) begin
        if (expq.size() == 0) check("unexpected_output", out_valid_o, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          check("result_r", out_r_o, e.r);
          check("result_tag", out_tag_o, e.tag);
          if (check_lat) check("latency", 128'(cyc - e.c), LAT);
          log_r.push_back(out_r_o);
          log_t.push_back(out_tag_o);
        end
      end
      if (in_valid_i && in_ready_o)
        expq.push_back('{mont_ref(in_x_i, cm, ck), in_tag_i, cyc});
      prev_stall = out_valid_o && !out_ready_i;
      prev_r = out_r_o;
      prev_t = out_tag_o;
    end
  end

  always @(posedge clk_i) if (rand_ready) begin #1; out_ready_i = 1'($urandom_range(1)); end

  task automatic do_cfg(input logic [63:0] m, input logic [63:0] minv, input logic [6:0] k,
                        input bit exp_rej, input string nm);
    cfg_m_i = m; cfg_minv_i = minv; cfg_k_i = k; cfg_we_i = 1;
    @(posedge clk_i); #1;
    cfg_we_i = 0;
    check({nm, "_rej"}, cfg_rej_o, exp_rej);
    if (!exp_rej) begin cm = m; ck = int'(k); end
    @(posedge clk_i); #1;
    check({nm, "_rej_pulse"}, cfg_rej_o, 0);
  endtask

  task automatic send(input logic [127:0] x, input logic [3:0] tag, input int gap);
    bit acc = 0;
    int guard = 0;
    while ($urandom_range(99) < gap) begin in_valid_i = 0; @(posedge clk_i); #1; end
    in_valid_i = 1; in_x_i = x; in_tag_i = tag;
    while (!acc && guard < 300) begin
      @(negedge clk_i); acc = in_ready_o;
      @(posedge clk_i); #1; guard++;
    end
    if (!acc) check("accept_timeout", in_ready_o, 1);
    in_valid_i = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy_o || expq.size() != 0) && n < 2000) begin @(posedge clk_i); #1; n++; end
    check({nm, "_drain_busy"}, busy_o, 0);
    check({nm, "_drain_queue"}, expq.size(), 0);
  endtask

  task automatic expect_last(input string nm, input logic [63:0] r, input logic [3:0] t, input int back);
    if (log_r.size() < back) check({nm, "_missing"}, log_r.size(), back);
    else begin
      check({nm, "_r"}, log_r[log_r.size()-back], r);
      check({nm, "_tag"}, log_t[log_t.size()-back], t);
    end
  endtask

  initial begin
    int n0;
    logic [63:0] m;
    int k;
    logic [127:0] bound, x;
    rst_ni = 0; cfg_we_i = 0; cfg_m_i = '0; cfg_minv_i = '0; cfg_k_i = '0;
    in_valid_i = 0; in_x_i = '0; in_tag_i = '0; out_ready_i = 1;
    repeat (3) @(posedge clk_i); #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_out_r", out_r_o, 0);
    check("rst_out_tag", out_tag_o, 0);
    check("rst_cfg_rej", cfg_rej_o, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    check("model_100", mont_ref(100, 17, 5), 1);
    check("model_543", mont_ref(543, 17, 5), 9);
    check("model_t_eq_m", mont_ref(51, 17, 5), 0);
    check("model_minv", calc_minv(17) & 64'h1f, 15);

    in_valid_i = 1; in_x_i = 100; in_tag_i = 1;
    repeat (3) begin @(negedge clk_i); check("unconfigured_in_ready", in_ready_o, 0); @(posedge clk_i); #1; end
    in_valid_i = 0;

    do_cfg(17, 15, 5, 0, "cfg_init");
    check_lat = 1;
    send(100, 3, 0);
    wait_idle("first");
    expect_last("x100", 1, 3, 1);
    send(543, 1, 0);
    send(0, 2, 0);
    wait_idle("pair");
    expect_last("x543", 9, 1, 2);
    expect_last("x0", 0, 2, 1);
    send(51, 5, 0);
    wait_idle("t_eq_m");
    expect_last("x51", 0, 5, 1);

    send(100, 4, 0);
    do_cfg(13, 11, 4, 1, "cfg_busy");
    wait_idle("busy_cfg");
    do_cfg(16, 15, 5, 1, "cfg_even_m");
    do_cfg(17, 15, 0, 1, "cfg_k0");
    do_cfg(33, 15, 5, 1, "cfg_m_big");
    do_cfg(17, 15, 65, 1, "cfg_k_big");
    in_valid_i = 1; in_x_i = 100; in_tag_i = 6;
    cfg_we_i = 1; cfg_m_i = 13; cfg_minv_i = 11; cfg_k_i = 4;
    @(posedge clk_i); #1;
    in_valid_i = 0; cfg_we_i = 0;
    check("cfg_with_accept_rej", cfg_rej_o, 1);
    wait_idle("same_cycle");
    send(100, 7, 0);
    wait_idle("old_cfg");
    expect_last("old_cfg_x100", 1, 7, 1);
    check_lat = 0;

    n0 = log_r.size();
    fork
      for (int i = 0; i < 8; i++) send(128'(i*37 + 5), 4'(i + 8), 0);
      begin
        repeat (7) @(posedge clk_i); #1;
        out_ready_i = 0;
        @(negedge clk_i);
        check("stall_out_valid", out_valid_o, 1);
        check("stall_in_ready", in_ready_o, 0);
        repeat (4) @(posedge clk_i); #1;
        out_ready_i = 1;
      end
    join
    wait_idle("stall");
    check("stall_count", log_r.size() - n0, 8);
    expect_last("stall_first", mont_ref(5, 17, 5), 8, 8);
    expect_last("stall_last", mont_ref(264, 17, 5), 15, 1);

    for (int i = 0; i < 3; i++) send(128'(200 + i), 4'(i), 0);
    rst_ni = 0;
    repeat (2) begin @(negedge clk_i); check("in_reset_out_valid", out_valid_o, 0); end
    @(posedge clk_i); #1;
    rst_ni = 1;
    n0 = log_r.size();
    repeat (8) begin @(negedge clk_i); check("post_reset_out_valid", out_valid_o, 0); end
    @(posedge clk_i); #1;
    check("post_reset_in_ready", in_ready_o, 0);
    do_cfg(17, 15, 5, 0, "cfg_after_reset");
    send(100, 9, 0);
    wait_idle("after_reset");
    check("after_reset_count", log_r.size() - n0, 1);
    expect_last("after_reset_x100", 1, 9, 1);

    rand_ready = 1;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin k = 64; m = '1; end
        1: begin k = 1;  m = 1; end
        2: begin k = 64; m = 64'h8000_0000_0000_0001; end
        default: begin
          k = int'($urandom_range(64, 1));
          m = {$urandom, $urandom};
          if (k < 64) m = m & ((64'd1 << k) - 64'd1);
          m[0] = 1'b1;
        end
      endcase
      wait_idle("rand_idle");
      do_cfg(m, calc_minv(m), 7'(k), 0, "cfg_rand");
      bound = {64'b0, m} << k;
      send(0, 0, 0);
      send(bound - 128'd1, 1, 0);
      for (int i = 0; i < 14; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom} % bound;
        send(x, 4'(i), 30);
      end
    end
    wait_idle("rand_end");
    rand_ready = 0;
    @(posedge clk_i); #2;
    out_ready_i = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/montgomery_reduce_stream.md
MONTGOMERY_REDUCE_STREAM -- requirements
Module: montgomery_reduce_stream

Interface
REQ-001 Parameter W, default 64, meaning modulus/result width in bits (W >= 8).
REQ-002 Parameter MUL_STAGES, default 2, meaning register stages inside each of the two internal multipliers (>= 1).
REQ-003 Parameter TAG_W, default 4, meaning width of the sideband tag carried with each operand.
REQ-004 The reset is rst_ni, asynchronous, active-low; the clock is clk_i.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 cfg_we_i  in  1  config write strobe.
REQ-008 cfg_m_i  in  W  modulus m.
REQ-009 cfg_minv_i  in  W  minv = -m^-1 mod 2^k (low k bits used).
REQ-010 cfg_k_i  in  $clog2(W+1)  Montgomery exponent k, R = 2^k.
REQ-011 cfg_rej_o  out  1  one-cycle pulse: config write rejected.
REQ-012 in_valid_i / in_ready_o  in / out  1 / 1  operand handshake.
REQ-013 in_x_i  in  2W  operand x.
REQ-014 in_tag_i  in  TAG_W  operand tag.
REQ-015 out_valid_o / out_ready_i  out / in  1 / 1  result handshake.
REQ-016 out_r_o  out  W  result.
REQ-017 out_tag_o  out  TAG_W  tag of the result.
REQ-018 busy_o  out  1  high while any pipeline stage holds a valid operand.

Function
REQ-019 Config is accepted on cfg_we_i only when: busy_o=0, cfg_m_i is odd, 1 <= cfg_k_i <= W and cfg_m_i < 2^cfg_k_i; when accepted, m/minv/k are latched and the configured flag is set.
REQ-020 Any other cfg_we_i is dropped, pulses cfg_rej_o the next cycle and leaves the existing config unchanged.
REQ-021 in_ready_o = configured AND NOT stall, where stall = out_valid_o AND NOT out_ready_i.
REQ-022 An operand is accepted when in_valid_i AND in_ready_o; the data is defined only for x < m*2^k.
REQ-023 Datapath: q = ((x mod 2^k) * minv) mod 2^k; t = (x + q*m) >> k, computed at 2W+1 bits without truncation; r = (t >= m) ? t - m : t.
REQ-024 Pipeline stages: input register (1), multiplier q (MUL_STAGES), multiplier q*m (MUL_STAGES), add/shift/subtract register (1); total latency LAT = 2*MUL_STAGES+2.
REQ-025 With no stall, the result of an operand accepted at cycle n appears with out_valid_o=1 at cycle n+LAT.
REQ-026 Initiation interval is 1: back-to-back accepts produce back-to-back results in acceptance order, each with its own tag.
REQ-027 x and tag travel with their operand through every stage via per-stage valid bits; there are no bubbles and no reordering.
REQ-028 A stall freezes all stages, including valid bits, and out_r_o/out_tag_o hold stable while out_valid_o=1 and out_ready_i=0.
REQ-029 A cycle with out_ready_i=1 and a valid output advances the pipeline; accept and drain in the same cycle is permitted.
REQ-030 cfg_we_i in the same cycle as an operand accept is rejected, because busy_o is considered high.
REQ-031 x = 0 yields r = 0; t = m exactly yields r = 0.

Reset
REQ-032 Reset clears all stage valid bits, the configured flag, and cfg_rej_o, and drives out_valid_o=0, in_ready_o=0, busy_o=0, out_r_o=0 and out_tag_o=0.
REQ-033 Reset mid-operation discards all in-flight operands with no output; the bench reconfigures after reset.
REQ-034 Datapath payload registers other than the outputs need no reset.

Verification
REQ-035 W=64, MUL_STAGES=2; configure m=17, minv=15, k=5; send x=100, tag=3 -> out_r_o=1, out_tag_o=3 exactly 6 cycles after accept.
REQ-036 Send x=543, tag=1, then x=0, tag=2 on consecutive cycles -> results 9 then 0 on consecutive cycles, tags 1 then 2.
REQ-037 Stream 8 operands with out_ready_i held 0 for 4 cycles mid-stream -> output held stable, in_ready_o=0 during the stall, no loss/duplication, order preserved.
REQ-038 cfg_we_i while busy_o=1, and also cfg_we_i with m=16 -> cfg_rej_o pulses and the old config still yields 100 -> 1.
REQ-039 Before any config, in_valid_i=1 -> in_ready_o=0; assert rst_ni low with 3 operands in flight -> out_valid_o stays 0 and no stale result appears after reconfig.
REQ-040 Random test: m odd, k in 1..64, x < m*2^k, random valid/ready -> every out_r_o equals x*2^-k mod m from a reference model.
